// File: rtl/dmem_arb_defs.sv
// Shared definitions for the data-memory arbiter: sequencer state
// encodings and requester identifiers.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input request picker. Bit 0 is the CPU and bit 1 is the debug port.
// On a tie it favours the CPU in fixed-priority mode. Otherwise it favours
// the requester that did not win last.
module rr_arb2
    import dmem_arb_defs::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick a winner from the current request pair
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        case (req)
            2'b01: gnt_id = REQ_CPU;
            2'b10: gnt_id = REQ_DBG;
            2'b11: begin
                if (fixed_prio) begin
                    gnt_id = REQ_CPU;
                end else begin
                    gnt_id = ~last;
                end
            end
            default: gnt_id = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path and the
// debug/loader port. Each word transfer runs IDLE -> ACCESS -> RESP.
// All memory-side and response outputs come straight from flops, so a
// rising reset clears them (including mem_we) without waiting for a clock.
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int DATA_W     = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam logic FIXED_PRIO_L = (FIXED_PRIO != 0);

    // True when the word address maps onto an implemented memory word
    function automatic logic in_range(input logic [DATA_W-1:0] addr);
        logic [32:0] addr_ext;
        logic [32:0] lim_ext;
        addr_ext = 33'(addr);
        lim_ext  = 33'(MEM_DEPTH);
        return (addr_ext < lim_ext);
    endfunction

    arb_state_e        state_q,     state_d;
    logic              cmd_we_q,    cmd_we_d;
    logic              oor_q,       oor_d;
    logic [DATA_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              grant_q,     grant_d;
    logic              rr_last_q,   rr_last_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              dbg_ack_q,   dbg_ack_d;
    logic              busy_q,      busy_d;

    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic              sel_we_s;
    logic [DATA_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_in_range_s;

    rr_arb2 u_pick (
        .req        ({dbg_req, cpu_req}),
        .last       (rr_last_q),
        .fixed_prio (FIXED_PRIO_L),
        .gnt_valid  (gnt_valid_s),
        .gnt_id     (gnt_id_s)
    );

    // Route the winning requester's command toward the latch
    always_comb begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
        if (gnt_id_s == REQ_DBG) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
        sel_in_range_s = in_range(sel_addr_s);
    end

    // Sequencer next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (gnt_valid_s) begin
                    // The command is latched here, so requester changes
                    // later in the transfer have no effect.
                    cmd_we_d    = sel_we_s;
                    oor_d       = ~sel_in_range_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    mem_we_d    = sel_we_s & sel_in_range_s;
                    grant_d     = gnt_id_s;
                    rr_last_d   = gnt_id_s;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!oor_q && !cmd_we_q) begin
                    rdata_d = mem_rdata;
                end else begin
                    rdata_d = '0;
                end
                err_d     = oor_q;
                cpu_ack_d = (grant_q == REQ_CPU);
                dbg_ack_d = (grant_q == REQ_DBG);
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_we_q    <= 1'b0;
            oor_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            grant_q     <= REQ_CPU;
            rr_last_q   <= REQ_DBG;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            oor_q       <= oor_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Instance 0 is round-robin and instance 1 is
// fixed-priority. Both instances share the requester inputs, and each
// drives its own bench memory.
module tb_dmem_arbiter;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [DW-1:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

    logic [1:0]    cpu_ack, dbg_ack, rsp_err, mem_we, busy, grant_id;
    logic [DW-1:0] rsp_rdata [2];
    logic [DW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];

    logic [DW-1:0] bmem    [2][256];
    logic [DW-1:0] ref_mem [2][256];
    logic          ref_last[2];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_W(DW), .MEM_DEPTH(256), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .grant_id(grant_id[0])
    );

    dmem_arbiter #(.DATA_W(DW), .MEM_DEPTH(256), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .grant_id(grant_id[1])
    );

    // Bench memories: combinational read, write on the rising edge
    assign mem_rdata[0] = (mem_addr[0] < 16'd256) ? bmem[0][mem_addr[0][7:0]] : 16'hDEAD;
    assign mem_rdata[1] = (mem_addr[1] < 16'd256) ? bmem[1][mem_addr[1][7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 256; j++)
                    bmem[i][j] <= 16'hA000 + 16'(j);
        end else begin
            for (int i = 0; i < 2; i++)
                if (mem_we[i] && mem_addr[i] < 16'd256)
                    bmem[i][mem_addr[i][7:0]] <= mem_wdata[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int cyc, input logic c, input logic d,
                                         input logic [15:0] rd, input logic er,
                                         input int wc, input logic [15:0] wa);
        return {13'd0, 8'(cyc), c, d, rd, er, 8'(wc), wa};
    endfunction

    // Transaction-level reference: winner by the arbitration rules, a
    // plain word array for memory, and out-of-range reads return 0.
    task automatic model_txn(input int inst,
                             input logic creq, input logic cwe, input logic [15:0] ca, input logic [15:0] cd,
                             input logic dreq, input logic dwe, input logic [15:0] da, input logic [15:0] dd,
                             output logic [63:0] exp);
        logic w, we, inr;
        logic [15:0] a, wd, rd;
        if (creq && !dreq)      w = 1'b0;
        else if (dreq && !creq) w = 1'b1;
        else if (inst == 1)     w = 1'b0;
        else                    w = ~ref_last[inst];
        ref_last[inst] = w;
        we  = w ? dwe : cwe;
        a   = w ? da : ca;
        wd  = w ? dd : cd;
        inr = (a < 16'd256);
        rd  = (inr && !we) ? ref_mem[inst][a[7:0]] : 16'h0000;
        if (we && inr) ref_mem[inst][a[7:0]] = wd;
        exp = pack(2, ~w, w, rd, ~inr, (we && inr) ? 1 : 0, (we && inr) ? a : 16'h0000);
    endtask

    // Drive one request set from idle and observe both instances until each acks
    task automatic do_txn(input logic creq, input logic cwe, input logic [15:0] ca, input logic [15:0] cd,
                          input logic dreq, input logic dwe, input logic [15:0] da, input logic [15:0] dd,
                          output logic [63:0] r0, output logic [63:0] r1);
        int ack_k[2]; logic ck[2]; logic dk[2]; logic [15:0] rd[2]; logic er[2]; int wc[2]; logic [15:0] wa[2];
        for (int i = 0; i < 2; i++) begin
            ack_k[i] = 0; ck[i] = 1'b0; dk[i] = 1'b0; rd[i] = 16'h0; er[i] = 1'b0; wc[i] = 0; wa[i] = 16'h0;
        end
        @(negedge clk);
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("ack_exclusive", 64'(cpu_ack[i] & dbg_ack[i]), 64'd0);
                if (mem_we[i]) begin wc[i]++; wa[i] = mem_addr[i]; end
                if (ack_k[i] == 0 && (cpu_ack[i] || dbg_ack[i])) begin
                    ack_k[i] = k; ck[i] = cpu_ack[i]; dk[i] = dbg_ack[i];
                    rd[i] = rsp_rdata[i]; er[i] = rsp_err[i];
                end
            end
            if (ack_k[0] != 0 && ack_k[1] != 0) break;
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        r0 = pack(ack_k[0], ck[0], dk[0], rd[0], er[0], wc[0], wa[0]);
        r1 = pack(ack_k[1], ck[1], dk[1], rd[1], er[1], wc[1], wa[1]);
    endtask

    // One transaction checked against the reference for both instances
    task automatic run_txn(input logic creq, input logic cwe, input logic [15:0] ca, input logic [15:0] cd,
                           input logic dreq, input logic dwe, input logic [15:0] da, input logic [15:0] dd,
                           output logic [63:0] r_rr);
        logic [63:0] r0, r1, e0, e1;
        do_txn(creq, cwe, ca, cd, dreq, dwe, da, dd, r0, r1);
        model_txn(0, creq, cwe, ca, cd, dreq, dwe, da, dd, e0);
        model_txn(1, creq, cwe, ca, cd, dreq, dwe, da, dd, e1);
        chk("model_rr", r0, e0);
        chk("model_fp", r1, e1);
        r_rr = r0;
    endtask

    function automatic logic [15:0] rand_addr();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 16'h0000;
        if (s == 1) return 16'h00FF;
        if (s == 2) return 16'(256 + $urandom_range(0, 65279));
        return 16'($urandom_range(0, 255));
    endfunction

    typedef struct {
        logic creq; logic cwe; logic [15:0] ca; logic [15:0] cd;
        logic dreq; logic dwe; logic [15:0] da; logic [15:0] dd;
        logic ec; logic ed; logic [15:0] erd; logic eerr; int ewe; logic [15:0] ewa;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [63:0] r;
        int seq0[$];
        int seq1[$];
        int served, acks, cpu_cnt, first;

        tbl[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 16'h0010};
        tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0, 0, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hA0FF, 1'b0, 0, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b0, 1, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h5A5A, 1'b0, 0, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'hA002, 1'b0, 0, 16'h0000};
        tbl[7] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'hA001, 1'b0, 0, 16'h0000};
        tbl[8] = '{1'b1, 1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 16'h00FF};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 1'b0, 0, 16'h0000};

        reset = 1'b1; preload = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        for (int i = 0; i < 2; i++) begin
            ref_last[i] = 1'b1;
            for (int j = 0; j < 256; j++) ref_mem[i][j] = 16'hA000 + 16'(j);
        end

        @(posedge clk); #1;
        preload = 1'b0;
        for (int i = 0; i < 2; i++)
            chk("reset_outputs", 64'({cpu_ack[i], dbg_ack[i], rsp_rdata[i], rsp_err[i], mem_we[i],
                                      mem_addr[i], mem_wdata[i], busy[i], grant_id[i]}), 64'd0);
        @(negedge clk); reset = 1'b0;

        // Reset during the ACCESS cycle of a write
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hA020;
        @(posedge clk); #1;
        chk("abort_access_entered", 64'({mem_we, busy}), 64'hF);
        #2 reset = 1'b1;
        #1;
        chk("abort_we_busy_drop", 64'({mem_we, busy, cpu_ack, dbg_ack}), 64'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        ref_last[0] = 1'b1; ref_last[1] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_ack", 64'({cpu_ack, dbg_ack}), 64'd0);
        end
        @(negedge clk); reset = 1'b0;
        run_txn(1'b1, 1'b0, 16'h0011, 16'h0, 1'b1, 1'b0, 16'h0012, 16'h0, r);
        chk("post_reset_cpu_wins", r, pack(2, 1'b1, 1'b0, 16'hA011, 1'b0, 0, 16'h0000));

        // Directed vectors against the round-robin instance
        for (int t = 0; t < 10; t++) begin
            run_txn(tbl[t].creq, tbl[t].cwe, tbl[t].ca, tbl[t].cd,
                    tbl[t].dreq, tbl[t].dwe, tbl[t].da, tbl[t].dd, r);
            chk($sformatf("table_%0d", t), r,
                pack(2, tbl[t].ec, tbl[t].ed, tbl[t].erd, tbl[t].eerr, tbl[t].ewe, tbl[t].ewa));
        end

        // Continuous contention: RR alternates, fixed priority serves CPU only
        first = ref_last[0] ? 0 : 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0006;
        for (int k = 0; k < 30 && seq1.size() < 5; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("cont_ack_exclusive", 64'(cpu_ack[i] & dbg_ack[i]), 64'd0);
                if (cpu_ack[i] || dbg_ack[i]) begin
                    if (i == 0) seq0.push_back(dbg_ack[i] ? 1 : 0);
                    else        seq1.push_back(dbg_ack[i] ? 1 : 0);
                    chk("cont_rdata", 64'(rsp_rdata[i]),
                        64'(dbg_ack[i] ? ref_mem[i][6] : ref_mem[i][5]));
                end
            end
        end
        cpu_cnt = 0;
        foreach (seq1[j]) if (seq1[j] == 0) cpu_cnt++;
        chk("fp_five_cpu_zero_dbg", 64'({8'(seq1.size()), 8'(cpu_cnt)}), 64'h0505);
        @(negedge clk); cpu_req = 1'b0;
        served = 0;
        for (int k = 1; k <= 6 && served == 0; k++) begin
            @(posedge clk); #1;
            if (cpu_ack[0] || dbg_ack[0]) seq0.push_back(dbg_ack[0] ? 1 : 0);
            if (dbg_ack[1]) served = k;
        end
        chk("fp_dbg_within_3", 64'(served >= 1 && served <= 3), 64'd1);
        @(negedge clk); dbg_req = 1'b0;
        chk("rr_seq_len", 64'(seq0.size()), 64'd6);
        for (int j = 0; j < 6 && j < seq0.size(); j++)
            chk($sformatf("rr_seq_%0d", j), 64'(seq0[j]), 64'(j == 5 ? 1 : (first ^ (j & 1))));
        ref_last[0] = 1'b1; ref_last[1] = 1'b1;
        repeat (2) @(posedge clk);

        // CPU withdraws its request during ACCESS
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        @(posedge clk); #1;
        chk("wd_busy", 64'(busy), 64'h3);
        @(negedge clk); cpu_req = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cpu_ack[0]) begin
                acks++;
                chk("wd_rdata", 64'(rsp_rdata[0]), 64'(ref_mem[0][8'h30]));
            end
            chk("wd_no_dbg_ack", 64'(dbg_ack), 64'd0);
        end
        chk("wd_single_ack", 64'(acks), 64'd1);
        chk("wd_idle_after", 64'({busy, mem_we}), 64'd0);
        ref_last[0] = 1'b0; ref_last[1] = 1'b0;

        // Randomized transactions against the reference
        for (int n = 0; n < 40; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            run_txn(sel[0], 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom_range(0, 65535)),
                    sel[1], 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom_range(0, 65535)), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
